seg_scan_ctrl: RTL

Time-multiplexed display controller that shares the team's single 4-bit seven-segment decoder (dec7seg_4bits) across N common-anode digits. It accepts a packed BCD value through a valid/ready handshake, double-buffers it so that updates land only on frame boundaries, and scans the digits with a blanking gap between them to suppress ghosting. It sits between the Genius game core (score/level value) and the board's segment/anode pins.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/dec7seg_4bits.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns,
// scan FSM state encoding and default timing.
package seg_pkg;

  // Segment patterns are ordered {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;

  localparam int DEF_DWELL     = 50000;
  localparam int DEF_BLANK_CYC = 500;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/dec7seg_4bits.sv
// Shared 4-bit to seven-segment decoder; nibbles above 9 leave the digit dark.
module dec7seg_4bits
  import seg_pkg::*;
(
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bin)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode display scanner with frame-synchronous value update.
// Optional leading-zero suppression: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DWELL     = DEF_DWELL,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an
);

  localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [4*N_DIGITS-1:0] disp_val_reg;
  logic [4*N_DIGITS-1:0] pend_val_reg;
  logic                  pend_flag_reg;
  logic [6:0]            seg_reg;
  logic [N_DIGITS-1:0]   an_reg;

  logic                  blank_last;
  logic                  show_last;
  logic                  idx_wrap;
  logic [IDX_W-1:0]      idx_next;
  logic                  frame_commit;
  logic [4*N_DIGITS-1:0] disp_val_next;
  logic [3:0]            dec_nib;
  logic [6:0]            dec_seg;
  logic [N_DIGITS-1:0]   an_show;

  assign blank_last    = (cnt_reg == CNT_W'(BLANK_CYC - 1));
  assign show_last     = (cnt_reg == CNT_W'(DWELL - 1));
  assign idx_wrap      = (idx_reg == IDX_W'(N_DIGITS - 1));
  assign idx_next      = idx_wrap ? '0 : idx_reg + IDX_W'(1);
  assign frame_commit  = (state_reg == ST_SHOW) && show_last && idx_wrap && pend_flag_reg;
  assign disp_val_next = frame_commit ? pend_val_reg : disp_val_reg;

  // On the SHOW->BLANK edge the decoder already looks at the upcoming digit,
  // so seg settles the moment the anodes go dark.
  assign dec_nib = ((state_reg == ST_SHOW) && show_last)
                   ? disp_val_next[{idx_next, 2'b00} +: 4]
                   : disp_val_reg[{idx_reg, 2'b00} +: 4];

  dec7seg_4bits u_dec (
    .bin (dec_nib),
    .seg (dec_seg)
  );

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_an
    logic lit;
    if (gi == 0) begin : g_first
      assign lit = 1'b1;
    end else begin : g_rest
`ifdef SEG_LEADING_ZERO_BLANK_EN
      // Dark when this nibble and every more significant nibble is zero.
      assign lit = |disp_val_reg[4*N_DIGITS-1:4*gi];
`else
      assign lit = 1'b1;
`endif
    end
    assign an_show[gi] = ~((idx_reg == IDX_W'(gi)) & lit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_BLANK;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      disp_val_reg  <= '0;
      pend_val_reg  <= '0;
      pend_flag_reg <= 1'b0;
      seg_reg       <= SEG_OFF;
      an_reg        <= '1;
    end else begin
      // A commit only happens while pend_flag is set, i.e. while no load can be
      // accepted, so the two updates below never collide.
      if (load && !pend_flag_reg) begin
        pend_val_reg  <= value;
        pend_flag_reg <= 1'b1;
      end
      case (state_reg)
        ST_BLANK: begin
          seg_reg <= dec_seg;
          if (blank_last) begin
            state_reg <= ST_SHOW;
            cnt_reg   <= '0;
            an_reg    <= an_show;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (show_last) begin
            state_reg <= ST_BLANK;
            cnt_reg   <= '0;
            idx_reg   <= idx_next;
            an_reg    <= '1;
            seg_reg   <= dec_seg;
            if (frame_commit) begin
              disp_val_reg  <= pend_val_reg;
              pend_flag_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_BLANK;
          cnt_reg   <= '0;
          an_reg    <= '1;
        end
      endcase
    end
  end

  assign ready = !pend_flag_reg;
  assign seg   = seg_reg;
  assign an    = an_reg;

endmodule
